dimm_cmd_tracker: RTL

Multi-rank DDR4 command front end for the DRAM emulation DIMM: it decodes act_n/A/cs_n command encodings, tracks the open row of every bank in every rank, and sequences read/write bursts through CAS latency and burst length. It drives column addresses, data-valid strobes and the dq output enable toward the chip/bank storage. It replaces single-rank, latency-free command handling with parametrised ranks, latencies and burst wrap.

---
 rtl/dimm_cmd_tracker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dimm_cmd_tracker.sv
// DDR4 multi-rank command front end: decodes commands, tracks open rows and sequences bursts.
// Optional feature macro: PARITY_CHECK_EN (command/address parity check with alert_n).
module dimm_cmd_tracker #(
  parameter int RANKS     = 2,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int CL        = 11,
  parameter int CWL       = 9
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        cke,
  input  logic [RANKS-1:0]                            cs_n,
  input  logic                                        act_n,
  input  logic [ADDRWIDTH-1:0]                        A,
  input  logic [BGWIDTH-1:0]                          bg,
  input  logic [BAWIDTH-1:0]                          ba,
  input  logic                                        parity,
  output logic [RANKS*(2**(BGWIDTH+BAWIDTH))-1:0]     open_mask,
  output logic [ADDRWIDTH-1:0]                        row_o,
  output logic [COLWIDTH-1:0]                         col_o,
  output logic [((RANKS>1)?$clog2(RANKS):1)-1:0]      rank_o,
  output logic [BGWIDTH-1:0]                          bg_o,
  output logic [BAWIDTH-1:0]                          ba_o,
  output logic                                        rd_valid,
  output logic                                        wr_valid,
  output logic                                        dq_oe,
  output logic                                        err,
  output logic                                        alert_n
);
  localparam int BANKBITS = BGWIDTH + BAWIDTH;
  localparam int BANKS    = 2 ** BANKBITS;
  localparam int NBANK    = RANKS * BANKS;
  localparam int RW       = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int KW       = RW + BANKBITS;
  localparam int BLB      = $clog2(BL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LAT   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [1:0]           state;
  logic [4:0]           lat_cnt;
  logic [2:0]           beat_cnt;
  logic                 dir_wr;
  logic                 auto_pre;
  logic [ADDRWIDTH-1:0] rows [NBANK];

  logic [RANKS-1:0] lows;
  logic             sel_any, sel_multi, parity_bad, cmd_ok;
  logic [RW-1:0]    cmd_rank;
  logic [KW-1:0]    cmd_idx, cur_idx;
  logic [NBANK-1:0] rank_mask, open_next;
  logic             is_act, is_rd, is_wr, is_pr, is_ref;
  logic             bank_open, can_accept, inflight, pr_hits, accept, err_next;
  logic [2:0]       rcw;

  assign lows      = ~cs_n;
  assign sel_any   = cke & (|lows);
  assign sel_multi = cke & (|(lows & (lows - RANKS'(1))));

`ifdef PARITY_CHECK_EN
  assign parity_bad = sel_any & (^{act_n, A, bg, ba, parity});
`else
  // Parity is ignored in this build; the AND keeps the input formally consumed.
  assign parity_bad = 1'b0 & parity;
`endif

  assign cmd_ok = sel_any & ~sel_multi & ~parity_bad;

  always_comb begin
    cmd_rank = '0;
    for (int i = 0; i < RANKS; i++)
      if (lows[i]) cmd_rank = RW'(i);
  end

  // Bank index {rank,bg,ba} equals rank*banks + bg*2^BAWIDTH + ba.
  assign cmd_idx = {cmd_rank, bg, ba};
  assign cur_idx = {rank_o, bg_o, ba_o};

  assign rcw    = A[16:14];
  assign is_act = cmd_ok & ~act_n;
  assign is_rd  = cmd_ok & act_n & (rcw == 3'b101);
  assign is_wr  = cmd_ok & act_n & (rcw == 3'b100);
  assign is_pr  = cmd_ok & act_n & (rcw == 3'b010);
  assign is_ref = cmd_ok & act_n & (rcw == 3'b001);

  assign bank_open  = open_mask[cmd_idx];
  assign can_accept = (state == S_IDLE) || ((state == S_BURST) && (beat_cnt == 3'd0));
  assign inflight   = (state != S_IDLE);
  assign pr_hits    = inflight && (A[10] ? (cmd_rank == rank_o) : (cmd_idx == cur_idx));

  always_comb begin
    rank_mask = '0;
    rank_mask[cmd_rank*BANKS +: BANKS] = '1;
  end

  always_comb begin
    open_next = open_mask;
    err_next  = sel_multi & ~parity_bad;
    accept    = 1'b0;
    // Auto-precharge closes the bank on the edge that enters the last beat pair.
    if ((state == S_BURST) && (beat_cnt == 3'd1) && auto_pre)
      open_next[cur_idx] = 1'b0;
    if (is_act) begin
      if (bank_open) err_next = 1'b1;
      else           open_next[cmd_idx] = 1'b1;
    end
    if (is_rd || is_wr) begin
      if (!bank_open || !can_accept) err_next = 1'b1;
      else                           accept   = 1'b1;
    end
    if (is_pr) begin
      if (pr_hits) err_next = 1'b1;
      if (A[10]) open_next = open_next & ~rank_mask;
      else       open_next[cmd_idx] = 1'b0;
    end
    if (is_ref && ((open_mask & rank_mask) != '0))
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_mask <= '0;
      err       <= 1'b0;
      alert_n   <= 1'b1;
      for (int i = 0; i < NBANK; i++) rows[i] <= '0;
    end else begin
      open_mask <= open_next;
      err       <= err_next;
      alert_n   <= ~parity_bad;
      if (is_act && !bank_open) rows[cmd_idx] <= A;
    end
  end

  // Burst sequencer: latency countdown, then BL/2 clocks of wrapping column beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      dir_wr   <= 1'b0;
      auto_pre <= 1'b0;
      row_o    <= '0;
      col_o    <= '0;
      rank_o   <= '0;
      bg_o     <= '0;
      ba_o     <= '0;
    end else if (accept) begin
      state    <= S_LAT;
      lat_cnt  <= is_rd ? 5'(CL) : 5'(CWL);
      dir_wr   <= is_wr;
      auto_pre <= A[10];
      row_o    <= rows[cmd_idx];
      col_o    <= A[COLWIDTH-1:0];
      rank_o   <= cmd_rank;
      bg_o     <= bg;
      ba_o     <= ba;
    end else begin
      case (state)
        S_LAT: begin
          if (lat_cnt == 5'd0) begin
            state    <= S_BURST;
            beat_cnt <= 3'(BL/2 - 1);
          end else begin
            lat_cnt <= lat_cnt - 5'd1;
          end
        end
        S_BURST: begin
          col_o[BLB-1:0] <= col_o[BLB-1:0] + BLB'(2);
          if (beat_cnt == 3'd0) state <= S_IDLE;
          else                  beat_cnt <= beat_cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid = (state == S_BURST) & ~dir_wr;
  assign wr_valid = (state == S_BURST) & dir_wr;
  assign dq_oe    = rd_valid;

endmodule
